// File: rtl/multicycle_sequencer.sv
// Single-state-register sequencer for LDM immediate fetch, CALL, RET, RTI and interrupt entry.
// Drives stack push/pop word selection, fetch hold, flush bubbles and CCR save/restore.
module multicycle_sequencer #(
    parameter int         WORD_WIDTH   = 16,
    parameter int         PC_WIDTH     = 32,
    parameter int         FLUSH_CYCLES = 2,
    parameter logic [4:0] OP_LDM       = 5'h0C,
    parameter logic [4:0] OP_CALL      = 5'h18,
    parameter logic [4:0] OP_RET       = 5'h19,
    parameter logic [4:0] OP_RTI       = 5'h1A,
    localparam int        PC_WORDS     = PC_WIDTH / WORD_WIDTH,
    localparam int        IDX_W        = (PC_WORDS > 1) ? $clog2(PC_WORDS) : 1,
    localparam int        FCNT_W       = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [4:0]        opcode,
    input  logic              bubble,
    input  logic              int_req,
    output logic              hold_fetch,
    output logic              push_en,
    output logic              pop_en,
    output logic [IDX_W-1:0]  pc_word_idx,
    output logic              push_src,
    output logic              ldm_imm,
    output logic              flush,
    output logic [FCNT_W-1:0] flush_cnt,
    output logic              int_ack,
    output logic              ccr_save,
    output logic              ccr_restore
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LDM,
        S_PUSH,
        S_POP,
        S_FLUSH
    } state_t;

    typedef enum logic [1:0] {
        M_CALL,
        M_INT,
        M_RET,
        M_RTI
    } mode_t;

    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(PC_WORDS - 1);
    // With no flush cycles configured, a finished PUSH/POP goes straight back to IDLE.
    localparam state_t            POST_STATE = (FLUSH_CYCLES > 0) ? S_FLUSH : S_IDLE;
    localparam logic [FCNT_W-1:0] POST_FCNT  = FCNT_W'(FLUSH_CYCLES);

    state_t            r_state;
    mode_t             r_mode;
    logic [IDX_W-1:0]  r_idx;
    logic [FCNT_W-1:0] r_fcnt;
    logic              r_int_pending;

    logic w_take_int;
    logic w_in_push;
    logic w_in_pop;
    logic w_is_int;

    assign w_take_int = (r_state == S_IDLE) && !bubble && r_int_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_mode        <= M_CALL;
            r_idx         <= '0;
            r_fcnt        <= '0;
            r_int_pending <= 1'b0;
        end else begin
            // Entering interrupt service absorbs any request arriving on the same edge.
            r_int_pending <= w_take_int ? 1'b0 : (r_int_pending | int_req);
            if (!bubble) begin
                case (r_state)
                    S_IDLE: begin
                        if (r_int_pending) begin
                            r_state <= S_PUSH;
                            r_mode  <= M_INT;
                            r_idx   <= '0;
                        end else if (instr_valid && opcode == OP_LDM) begin
                            r_state <= S_LDM;
                        end else if (instr_valid && opcode == OP_CALL) begin
                            r_state <= S_PUSH;
                            r_mode  <= M_CALL;
                            r_idx   <= '0;
                        end else if (instr_valid && (opcode == OP_RET || opcode == OP_RTI)) begin
                            r_state <= S_POP;
                            r_mode  <= (opcode == OP_RTI) ? M_RTI : M_RET;
                            r_idx   <= IDX_LAST;
                        end
                    end
                    S_LDM: r_state <= S_IDLE;
                    S_PUSH: begin
                        if (r_idx == IDX_LAST) begin
                            r_idx   <= '0;
                            r_state <= POST_STATE;
                            r_fcnt  <= POST_FCNT;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                    S_POP: begin
                        if (r_idx == '0) begin
                            r_state <= POST_STATE;
                            r_fcnt  <= POST_FCNT;
                        end else begin
                            r_idx <= r_idx - 1'b1;
                        end
                    end
                    S_FLUSH: begin
                        r_fcnt <= r_fcnt - 1'b1;
                        if (r_fcnt == FCNT_W'(1)) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign w_in_push = (r_state == S_PUSH);
    assign w_in_pop  = (r_state == S_POP);
    assign w_is_int  = (r_mode == M_INT);

    // A stall masks every action but keeps fetch frozen so the sequence resumes intact.
    assign hold_fetch  = w_in_push || w_in_pop || (bubble && r_state != S_IDLE);
    assign push_en     = w_in_push && !bubble;
    assign pop_en      = w_in_pop && !bubble;
    assign ldm_imm     = (r_state == S_LDM) && !bubble;
    assign flush       = (r_state == S_FLUSH) && !bubble;
    assign pc_word_idx = (w_in_push || w_in_pop) ? r_idx : '0;
    assign push_src    = w_in_push && w_is_int;
    assign flush_cnt   = (r_state == S_FLUSH) ? r_fcnt : '0;
    assign int_ack     = push_en && w_is_int && (r_idx == '0);
    assign ccr_save    = push_en && w_is_int && (r_idx == '0);
    assign ccr_restore = pop_en && (r_mode == M_RTI) && (r_idx == '0);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: two configurations (32-bit PC with 2 flush cycles, 48-bit PC with none)
// driven by identical stimulus and compared every cycle against a per-instance script-queue model.
module tb_multicycle_sequencer;

    localparam logic [4:0] OP_LDM  = 5'h0C;
    localparam logic [4:0] OP_CALL = 5'h18;
    localparam logic [4:0] OP_RET  = 5'h19;
    localparam logic [4:0] OP_RTI  = 5'h1A;

    localparam int K_INT  = 0;
    localparam int K_CALL = 1;
    localparam int K_RET  = 2;
    localparam int K_RTI  = 3;
    localparam int K_LDM  = 4;

    typedef struct packed {
        logic       push;
        logic       pop;
        logic       ldm;
        logic       fl;
        logic       src;
        logic       ack;
        logic       save;
        logic       rest;
        logic [7:0] idx;
        logic [7:0] fcnt;
    } step_t;

    logic       clk;
    logic       rst_n;
    logic       instr_valid;
    logic [4:0] opcode;
    logic       bubble;
    logic       int_req;

    logic a_hold [2];
    logic a_push [2];
    logic a_pop  [2];
    logic a_src  [2];
    logic a_ldm  [2];
    logic a_fl   [2];
    logic a_ack  [2];
    logic a_save [2];
    logic a_rest [2];
    logic [0:0] idx0;
    logic [1:0] idx1;
    logic [1:0] fcnt0;
    logic [0:0] fcnt1;

    multicycle_sequencer #(.WORD_WIDTH(16), .PC_WIDTH(32), .FLUSH_CYCLES(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode),
        .bubble(bubble), .int_req(int_req), .hold_fetch(a_hold[0]), .push_en(a_push[0]),
        .pop_en(a_pop[0]), .pc_word_idx(idx0), .push_src(a_src[0]), .ldm_imm(a_ldm[0]),
        .flush(a_fl[0]), .flush_cnt(fcnt0), .int_ack(a_ack[0]), .ccr_save(a_save[0]),
        .ccr_restore(a_rest[0])
    );

    multicycle_sequencer #(.WORD_WIDTH(16), .PC_WIDTH(48), .FLUSH_CYCLES(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode),
        .bubble(bubble), .int_req(int_req), .hold_fetch(a_hold[1]), .push_en(a_push[1]),
        .pop_en(a_pop[1]), .pc_word_idx(idx1), .push_src(a_src[1]), .ldm_imm(a_ldm[1]),
        .flush(a_fl[1]), .flush_cnt(fcnt1), .int_ack(a_ack[1]), .ccr_save(a_save[1]),
        .ccr_restore(a_rest[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc_n   = 0;
    int    pc_words [2] = '{2, 3};
    int    flush_cy [2] = '{2, 0};
    step_t q [2][$];
    bit    pend [2];

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc_n, got, exp);
        end
    endtask

    // The expected behaviour of one accepted operation, written out as its sequence of output cycles.
    function automatic void build(input int u, input int kind);
        step_t s;
        if (kind == K_LDM) begin
            s = '0; s.ldm = 1'b1;
            q[u].push_back(s);
            return;
        end
        for (int i = 0; i < pc_words[u]; i++) begin
            s = '0;
            if (kind == K_INT || kind == K_CALL) begin
                s.push = 1'b1;
                s.idx  = 8'(i);
                s.src  = (kind == K_INT);
                s.ack  = (kind == K_INT) && (i == 0);
                s.save = s.ack;
            end else begin
                s.pop  = 1'b1;
                s.idx  = 8'(pc_words[u] - 1 - i);
                s.rest = (kind == K_RTI) && (s.idx == 8'd0);
            end
            q[u].push_back(s);
        end
        for (int k = flush_cy[u]; k >= 1; k--) begin
            s = '0; s.fl = 1'b1; s.fcnt = 8'(k);
            q[u].push_back(s);
        end
    endfunction

    function automatic void model_step(input int u);
        bit take;
        take = (q[u].size() == 0) && !bubble && pend[u];
        if (q[u].size() != 0) begin
            if (!bubble) void'(q[u].pop_front());
        end else if (!bubble) begin
            if (pend[u])                                         build(u, K_INT);
            else if (instr_valid && opcode == OP_LDM)            build(u, K_LDM);
            else if (instr_valid && opcode == OP_CALL)           build(u, K_CALL);
            else if (instr_valid && opcode == OP_RET)            build(u, K_RET);
            else if (instr_valid && opcode == OP_RTI)            build(u, K_RTI);
        end
        pend[u] = take ? 1'b0 : (pend[u] | int_req);
    endfunction

    task automatic compare(input int u);
        step_t e;
        int    hold, got_idx, got_fcnt, act;
        string p;
        e    = '0;
        hold = 0;
        if (q[u].size() != 0) begin
            e = q[u][0];
            if (bubble) begin
                e.push = 0; e.pop = 0; e.ldm = 0; e.fl = 0; e.ack = 0; e.save = 0; e.rest = 0;
                hold = 1;
            end else begin
                hold = e.push | e.pop;
            end
        end
        got_idx  = (u == 0) ? int'(idx0)  : int'(idx1);
        got_fcnt = (u == 0) ? int'(fcnt0) : int'(fcnt1);
        p = $sformatf("u%0d.", u);
        check_val({p, "hold_fetch"},  int'(a_hold[u]), hold);
        check_val({p, "push_en"},     int'(a_push[u]), int'(e.push));
        check_val({p, "pop_en"},      int'(a_pop[u]),  int'(e.pop));
        check_val({p, "ldm_imm"},     int'(a_ldm[u]),  int'(e.ldm));
        check_val({p, "flush"},       int'(a_fl[u]),   int'(e.fl));
        check_val({p, "push_src"},    int'(a_src[u]),  int'(e.src));
        check_val({p, "int_ack"},     int'(a_ack[u]),  int'(e.ack));
        check_val({p, "ccr_save"},    int'(a_save[u]), int'(e.save));
        check_val({p, "ccr_restore"}, int'(a_rest[u]), int'(e.rest));
        check_val({p, "pc_word_idx"}, got_idx,  int'(e.idx));
        check_val({p, "flush_cnt"},   got_fcnt, int'(e.fcnt));
        act = int'(a_push[u]) + int'(a_pop[u]) + int'(a_ldm[u]) + int'(a_fl[u]);
        check_val({p, "onehot_actions"}, int'(act <= 1), 1);
    endtask

    // Called just after a rising edge; checks at the falling edge, then advances the model.
    task automatic cyc(input logic v, input logic [4:0] op, input logic b, input logic irq);
        instr_valid = v;
        opcode      = op;
        bubble      = b;
        int_req     = irq;
        @(negedge clk);
        compare(0);
        compare(1);
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        instr_valid = 1'b0;
        opcode      = 5'd0;
        bubble      = 1'b0;
        int_req     = 1'b0;
        rst_n       = 1'b0;
        #1;
        for (int u = 0; u < 2; u++) begin
            q[u].delete();
            pend[u] = 1'b0;
        end
        compare(0);
        compare(1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int r;
        logic [4:0] op;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        opcode      = 5'd0;
        bubble      = 1'b0;
        int_req     = 1'b0;
        pend        = '{1'b0, 1'b0};
        repeat (2) @(posedge clk);
        #1;
        compare(0);
        compare(1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        cyc(1'b1, OP_CALL, 1'b0, 1'b0); idle(6);
        cyc(1'b1, OP_RTI,  1'b0, 1'b0); idle(6);
        cyc(1'b1, OP_LDM,  1'b0, 1'b0); cyc(1'b0, 5'd0, 1'b0, 1'b1); idle(8);
        cyc(1'b1, OP_RET,  1'b0, 1'b0);
        repeat (3) cyc(1'b0, 5'd0, 1'b1, 1'b0);
        idle(6);
        cyc(1'b1, OP_CALL, 1'b0, 1'b0); cyc(1'b0, 5'd0, 1'b0, 1'b1);
        do_reset();
        cyc(1'b1, OP_CALL, 1'b0, 1'b0); idle(6);
        cyc(1'b1, OP_CALL, 1'b0, 1'b0); cyc(1'b0, 5'd0, 1'b0, 1'b1);
        idle(1);
        cyc(1'b0, 5'd0, 1'b0, 1'b1); idle(12);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                r = $urandom_range(0, 7);
                case (r)
                    0:       op = OP_LDM;
                    1:       op = OP_CALL;
                    2:       op = OP_RET;
                    3:       op = OP_RTI;
                    default: op = 5'($urandom);
                endcase
                cyc(1'($urandom_range(0, 1)), op, 1'($urandom_range(0, 6) == 0),
                    1'($urandom_range(0, 19) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
